// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU and its control decoder.
//   - 4-bit ALU operation codes (same encoding the alu block decodes)
//   - RV32I major opcodes handled by the decoder
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Full decode result as held by the output register.
    typedef struct packed {
        logic [3:0]  alu_op;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_comb.sv
// alu_ctrl_comb: purely combinational RV32I -> ALU control decode.
// Ports:
//   instr      in  32  instruction word
//   alu_op     out 4   ALU operation (alu_pkg encoding)
//   use_imm    out 1   operand B takes imm instead of rs2
//   imm        out 32  sign-extended immediate (0 where unused)
//   rs1/rs2/rd out 5   raw register index fields
//   reg_write  out 1   result is written to rd
//   illegal    out 1   unsupported encoding; all control fields forced to 0
module alu_ctrl_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_op,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        funct7_zero;
    logic        funct7_alt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_shamt;
    logic [3:0]  base_op;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign funct7_zero = (funct7 == 7'b0000000);
    assign funct7_alt  = (funct7 == 7'b0100000);
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign rd          = instr[11:7];

    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    // Shift immediates carry only the shift amount; funct7 bits are opcode, not data.
    assign imm_shamt = {27'd0, instr[24:20]};

    // funct3 map shared by R-type and I-type ALU ops (alternate funct7 handled below).
    always_comb begin
        base_op = ALU_ADD;
        unique case (funct3)
            3'b000: base_op = ALU_ADD;
            3'b001: base_op = ALU_SLL;
            3'b010: base_op = ALU_SLT;
            3'b011: base_op = ALU_SLTU;
            3'b100: base_op = ALU_XOR;
            3'b101: base_op = ALU_SRL;
            3'b110: base_op = ALU_OR;
            3'b111: base_op = ALU_AND;
            default: base_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        imm       = '0;
        reg_write = 1'b0;
        illegal   = 1'b0;

        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = base_op;
                if (funct7_alt && funct3 == 3'b000) begin
                    alu_op = ALU_SUB;
                end else if (funct7_alt && funct3 == 3'b101) begin
                    alu_op = ALU_SRA;
                end else if (!funct7_zero) begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                reg_write = 1'b1;
                use_imm   = 1'b1;
                imm       = imm_i;
                alu_op    = base_op;
                if (funct3 == 3'b001) begin
                    imm = imm_shamt;
                    if (!funct7_zero) begin
                        illegal = 1'b1;
                    end
                end else if (funct3 == 3'b101) begin
                    imm = imm_shamt;
                    if (funct7_alt) begin
                        alu_op = ALU_SRA;
                    end else if (!funct7_zero) begin
                        illegal = 1'b1;
                    end
                end
            end
            OP_LOAD: begin
                reg_write = 1'b1;
                use_imm   = 1'b1;
                imm       = imm_i;
            end
            OP_STORE: begin
                use_imm = 1'b1;
                imm     = imm_s;
            end
            OP_BRANCH: begin
                unique case (funct3[2:1])
                    2'b00: alu_op = ALU_SUB;
                    2'b01: illegal = 1'b1;
                    2'b10: alu_op = ALU_SLT;
                    2'b11: alu_op = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        // Illegal encodings must not steer the datapath or write the register file.
        if (illegal) begin
            alu_op    = ALU_ADD;
            use_imm   = 1'b0;
            imm       = '0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: registered decode stage with valid/ready on both sides.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   inValid/inReady   upstream handshake (inReady = !outValid || outReady)
//   instr             instruction word
//   outValid/outReady downstream handshake
//   aluControl, useImm, imm, rs1, rs2, rd, regWrite, illegal  registered decode
//   illegalCount      saturating count of accepted illegal instructions,
//                     present only when ALU_DEC_ILLEGAL_CNT_EN is defined
module alu_ctrl_decoder
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] instr,
    output logic        outValid,
    input  logic        outReady,
    output logic [3:0]  aluControl,
    output logic        useImm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        regWrite,
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    output logic [15:0] illegalCount,
`endif
    output logic        illegal
);

    dec_t dec_d;
    dec_t dec_q;
    logic valid_q;
    logic accept;
    logic drain;

    alu_ctrl_comb u_comb (
        .instr     (instr),
        .alu_op    (dec_d.alu_op),
        .use_imm   (dec_d.use_imm),
        .imm       (dec_d.imm),
        .rs1       (dec_d.rs1),
        .rs2       (dec_d.rs2),
        .rd        (dec_d.rd),
        .reg_write (dec_d.reg_write),
        .illegal   (dec_d.illegal)
    );

    assign inReady = !valid_q || outReady;
    assign accept  = inValid && inReady;
    assign drain   = valid_q && outReady;

    // Accept has priority so a simultaneous accept+drain keeps outValid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            dec_q   <= dec_d;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [15:0] ill_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ill_cnt_q <= '0;
        end else if (accept && dec_d.illegal && ill_cnt_q != 16'hFFFF) begin
            ill_cnt_q <= ill_cnt_q + 16'd1;
        end
    end

    assign illegalCount = ill_cnt_q;
`endif

    assign outValid   = valid_q;
    assign aluControl = dec_q.alu_op;
    assign useImm     = dec_q.use_imm;
    assign imm        = dec_q.imm;
    assign rs1        = dec_q.rs1;
    assign rs2        = dec_q.rs2;
    assign rd         = dec_q.rd;
    assign regWrite   = dec_q.reg_write;
    assign illegal    = dec_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: directed cases then randomized handshake traffic
// checked against an instruction-level reference model.
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] instr;
    logic        outValid;
    logic        outReady;
    logic [3:0]  aluControl;
    logic        useImm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regWrite;
    logic        illegal;
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [15:0] illegalCount;
`endif

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    alu_ctrl_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .inValid    (inValid),
        .inReady    (inReady),
        .instr      (instr),
        .outValid   (outValid),
        .outReady   (outReady),
        .aluControl (aluControl),
        .useImm     (useImm),
        .imm        (imm),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .regWrite   (regWrite),
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        .illegalCount (illegalCount),
`endif
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        use_imm;
        logic [31:0] imm;
        logic        reg_write;
        logic        illegal;
    } exp_t;

    // Reference decode from the instruction-set rules.
    function automatic exp_t ref_decode(logic [31:0] w);
        exp_t e;
        int   alu_by_f3 [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        int   br_by_f3  [8] = '{1, 1, -1, -1, 8, 8, 9, 9};
        int   f3 = int'(w[14:12]);
        int   f7 = int'(w[31:25]);
        int   opc = int'(w[6:0]);
        logic [31:0] imm_i = {{20{w[31]}}, w[31:20]};
        logic [31:0] imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
        e.op = 4'd0; e.use_imm = 1'b0; e.imm = 32'd0; e.reg_write = 1'b0; e.illegal = 1'b0;
        if (opc == 'h33) begin
            e.reg_write = 1'b1;
            e.op = 4'(alu_by_f3[f3]);
            if (f7 == 'h20 && f3 == 0) e.op = 4'd1;
            else if (f7 == 'h20 && f3 == 5) e.op = 4'd7;
            else if (f7 != 0) e.illegal = 1'b1;
        end else if (opc == 'h13) begin
            e.reg_write = 1'b1;
            e.use_imm = 1'b1;
            e.op = 4'(alu_by_f3[f3]);
            e.imm = imm_i;
            if (f3 == 1 || f3 == 5) begin
                e.imm = 32'(w[24:20]);
                if (f3 == 5 && f7 == 'h20) e.op = 4'd7;
                else if (f7 != 0) e.illegal = 1'b1;
            end
        end else if (opc == 'h03) begin
            e.reg_write = 1'b1; e.use_imm = 1'b1; e.imm = imm_i;
        end else if (opc == 'h23) begin
            e.use_imm = 1'b1; e.imm = imm_s;
        end else if (opc == 'h63) begin
            if (br_by_f3[f3] < 0) e.illegal = 1'b1;
            else e.op = 4'(br_by_f3[f3]);
        end else begin
            e.illegal = 1'b1;
        end
        if (e.illegal) begin
            e.op = 4'd0; e.use_imm = 1'b0; e.imm = 32'd0; e.reg_write = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 7))
            0, 5: w[6:0] = 7'h33;
            1, 6: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(string tag, logic [31:0] w);
        exp_t e = ref_decode(w);
        chk({tag, ".outValid"}, 32'(outValid), 32'd1);
        chk({tag, ".aluControl"}, 32'(aluControl), 32'(e.op));
        chk({tag, ".useImm"}, 32'(useImm), 32'(e.use_imm));
        chk({tag, ".imm"}, imm, e.imm);
        chk({tag, ".regWrite"}, 32'(regWrite), 32'(e.reg_write));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e.illegal));
        chk({tag, ".rs1"}, 32'(rs1), 32'(w[19:15]));
        chk({tag, ".rs2"}, 32'(rs2), 32'(w[24:20]));
        chk({tag, ".rd"}, 32'(rd), 32'(w[11:7]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted instruction with the downstream ready.
    task automatic send(logic [31:0] w);
        inValid  = 1'b1;
        instr    = w;
        outReady = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    task automatic check_zero(string tag);
        chk({tag, ".outValid"}, 32'(outValid), 32'd0);
        chk({tag, ".fields"},
            32'({aluControl, useImm, regWrite, illegal, rs1, rs2, rd}), 32'd0);
        chk({tag, ".imm"}, imm, 32'd0);
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        chk({tag, ".illegalCount"}, 32'(illegalCount), 32'd0);
`endif
    endtask

    initial begin
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        accepted;
        logic        acc;

        reset = 1'b1; inValid = 1'b0; outReady = 1'b0; instr = 32'd0;
        #12;
        check_zero("reset");
        chk("reset.inReady", 32'(inReady), 32'd1);
        @(negedge clk) reset = 1'b0;

        send(32'h002081B3);
        check_out("add", 32'h002081B3);
        chk("add.aluControl_lit", 32'(aluControl), 32'd0);
        chk("add.rd_lit", 32'(rd), 32'd3);
        send(32'h402081B3);
        check_out("sub", 32'h402081B3);
        chk("sub.aluControl_lit", 32'(aluControl), 32'd1);
        send(32'h40335293);
        check_out("srai", 32'h40335293);
        chk("srai.lit", {24'd0, aluControl, useImm, 3'd0}, {24'd0, 4'b0111, 1'b1, 3'd0});
        chk("srai.imm_lit", imm, 32'h00000003);
        send(32'h0020C463);
        check_out("blt", 32'h0020C463);
        chk("blt.aluControl_lit", 32'(aluControl), 32'd8);

        // Mid-stream reset while a result is held.
        outReady = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero("midreset");
        chk("midreset.inReady", 32'(inReady), 32'd1);
        @(negedge clk) reset = 1'b0;

        // Backpressure: result held for 3 cycles with a new instruction waiting.
        send(32'h002081B3);
        outReady = 1'b0;
        inValid  = 1'b1;
        instr    = 32'h402081B3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp.inReady", 32'(inReady), 32'd0);
            check_out("bp.hold", 32'h002081B3);
        end
        outReady = 1'b1;
        #1 chk("bp.inReady_up", 32'(inReady), 32'd1);
        tick();
        check_out("bp.reload", 32'h402081B3);
        inValid = 1'b0;
        tick();
        chk("bp.drained", 32'(outValid), 32'd0);

        // Illegal encodings after a fresh reset.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        send(32'hFFFFFFFF);
        check_out("ill.ones", 32'hFFFFFFFF);
        chk("ill.ones_lit", 32'(illegal), 32'd1);
        send(32'h022081B3);
        check_out("ill.f7", 32'h022081B3);
        chk("ill.f7_lit", {30'd0, illegal, regWrite}, 32'b10);
        ecount = 2;
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        chk("ill.count", 32'(illegalCount), 32'd2);
`endif

        // Randomized traffic against the handshake/decode model.
        outReady  = 1'b1;
        tick();
        exp_valid = 1'b0;
        exp_instr = 32'd0;
        accepted  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (accepted || !inValid) begin
                inValid = ($urandom_range(0, 3) != 0);
                instr   = gen_instr();
            end
            outReady = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd.inReady", 32'(inReady), 32'(!exp_valid || outReady));
            acc = inValid && (!exp_valid || outReady);
            if (acc) begin
                exp_valid = 1'b1;
                exp_instr = instr;
                if (ref_decode(instr).illegal && ecount < 65535) ecount++;
            end else if (exp_valid && outReady) begin
                exp_valid = 1'b0;
            end
            accepted = acc;
            tick();
            if (exp_valid) check_out("rnd", exp_instr);
            else chk("rnd.outValid", 32'(outValid), 32'd0);
`ifdef ALU_DEC_ILLEGAL_CNT_EN
            chk("rnd.count", 32'(illegalCount), 32'(ecount));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
